alu_arbiter: RTL and testbench

Shares the single-cycle ALU between two requesters: the core datapath (port 0) and the address/loop-count unit (port 1). Each request carries an `op_mne` opcode and two operands, and the block arbitrates round-robin. It executes one operation at a time through an internal ALU, then returns a registered result to the requester that issued it, using a valid/ready handshake on both the request and response sides.

---
 rtl/alu_arbiter_pkg.sv | 23 ++
 rtl/alu_arbiter_alu_core.sv | 65 ++++++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter.
//   op_mne      : 3-bit ALU opcode carried by each request (3'b111 is illegal)
//   arb_state_t : arbiter FSM state
package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_LSL = 3'd1,
    OP_LSR = 3'd2,
    OP_XOR = 3'd3,
    OP_SNE = 3'd4,
    OP_SEQ = 3'd5,
    OP_MSK = 3'd6,
    OP_ILL = 3'd7
  } op_mne;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Combinational single-cycle ALU.
//   op     : opcode (op_mne)
//   a, b   : W-bit unsigned operands
//   result : W-bit result
//   flag   : carry-out for ADD, compare bit for SNE/SEQ, zero flag otherwise
//   err    : illegal opcode
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  op_mne          op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   result,
  output logic           flag,
  output logic           err
);

  logic [W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    flag   = 1'b0;
    err    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[W-1:0];
        flag   = sum[W];
      end
      OP_LSL: begin
        result = a << b[2:0];
        flag   = (result == '0);
      end
      OP_LSR: begin
        result = a >> b[2:0];
        flag   = (result == '0);
      end
      OP_XOR: begin
        result = a ^ b;
        flag   = (result == '0);
      end
      OP_SNE: begin
        result = {{(W-1){1'b0}}, (a != b)};
        flag   = result[0];
      end
      OP_SEQ: begin
        result = {{(W-1){1'b0}}, (a == b)};
        flag   = result[0];
      end
      OP_MSK: begin
        result = a & b;
        flag   = (result == '0);
      end
      default: begin
        result = '0;
        flag   = 1'b0;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
//   Clk, Reset_n             : clock, asynchronous active-low reset
//   reqN_valid/ready         : request handshake (ready combinational, IDLE only)
//   reqN_op, reqN_a, reqN_b  : request payload
//   rspN_valid/ready         : response handshake (only the owner's valid rises)
//   rspN_data/flag/err       : registered result, flag and illegal-op indication
//   busy                     : registered, high whenever the FSM is not IDLE
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  op_mne        req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  op_mne        req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp0_flag,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         rsp1_flag,
  output logic         rsp1_err,
  output logic         busy
);

  arb_state_t   state, state_nxt;
  logic         owner;
  logic         last_grant;
  logic         grant0, grant1, accept;
  logic         owner_ready;

  op_mne        op_q;
  logic [W-1:0] a_q, b_q;

  logic [W-1:0] alu_res;
  logic         alu_flag, alu_err;
  logic [W-1:0] res_q;
  logic         flag_q, err_q;
  logic         busy_q;

  // On a tie the port that did not win last time is granted.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  // Ready is also gated by Reset_n so that it reads 0 while reset is held,
  // even though the state register already sits in IDLE.
  assign req0_ready = Reset_n & (state == IDLE) & grant0;
  assign req1_ready = Reset_n & (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  assign owner_ready = owner ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = EXEC;
      EXEC:                     state_nxt = RESP;
      RESP:    if (owner_ready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      if (accept) begin
        owner      <= grant1;
        last_grant <= grant1;
      end
    end
  end

  // Operand capture at the request handshake; no reset needed, the values
  // are only consumed after a fresh capture.
  always_ff @(posedge Clk) begin
    if (accept) begin
      op_q <= grant1 ? req1_op : req0_op;
      a_q  <= grant1 ? req1_a  : req0_a;
      b_q  <= grant1 ? req1_b  : req0_b;
    end
  end

  alu_core #(.W(W)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .flag   (alu_flag),
    .err    (alu_err)
  );

  // Result registers load only in EXEC, so they hold steady through RESP.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      res_q  <= '0;
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state == EXEC) begin
      res_q  <= alu_res;
      flag_q <= alu_flag;
      err_q  <= alu_err;
    end
  end

  assign rsp0_valid = (state == RESP) & ~owner;
  assign rsp1_valid = (state == RESP) &  owner;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign rsp0_flag  = flag_q;
  assign rsp1_flag  = flag_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       Clk, Reset_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  op_mne      req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_flag, rsp1_flag, rsp0_err, rsp1_err;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;

  alu_arbiter #(.W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_flag(rsp0_flag), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_flag(rsp1_flag), .rsp1_err(rsp1_err),
    .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req0_ready"}, req0_ready, 0);
    check({tag, " req1_ready"}, req1_ready, 0);
    check({tag, " rsp0_valid"}, rsp0_valid, 0);
    check({tag, " rsp1_valid"}, rsp1_valid, 0);
    check({tag, " rsp0_data"},  rsp0_data,  0);
    check({tag, " rsp1_data"},  rsp1_data,  0);
    check({tag, " flags"}, {rsp0_flag, rsp1_flag, rsp0_err, rsp1_err}, 0);
    check({tag, " busy"}, busy, 0);
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // One isolated transaction on a single port, response taken at once.
  task automatic do_op(input bit port, input op_mne op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] ed, input bit ef,
                       input bit ee, input string tag);
    @(negedge Clk);
    if (port) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else      begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    check({tag, " req_ready"}, port ? req1_ready : req0_ready, 1);
    @(posedge Clk); #1;
    req0_valid = 0; req1_valid = 0;
    check({tag, " busy exec"}, busy, 1);
    @(posedge Clk); #1;
    check({tag, " rsp_valid"}, port ? rsp1_valid : rsp0_valid, 1);
    check({tag, " other rsp_valid"}, port ? rsp0_valid : rsp1_valid, 0);
    check({tag, " data"}, port ? rsp1_data : rsp0_data, ed);
    check({tag, " flag"}, port ? rsp1_flag : rsp0_flag, ef);
    check({tag, " err"},  port ? rsp1_err  : rsp0_err,  ee);
    if (port) rsp1_ready = 1; else rsp0_ready = 1;
    @(posedge Clk); #1;
    rsp0_ready = 0; rsp1_ready = 0;
    check({tag, " rsp done"}, rsp0_valid | rsp1_valid, 0);
    check({tag, " busy idle"}, busy, 0);
  endtask

  initial begin
    bit order [4];
    int got_n;
    int cyc;

    Reset_n = 0;
    req0_valid = 0; req1_valid = 0;
    req0_op = OP_ADD; req1_op = OP_ADD;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;

    #12;
    check_reset_outputs("por");
    @(negedge Clk);
    Reset_n = 1;

    // Single op: F0 + 20 = 0x110 -> 0x10 with carry
    do_op(0, OP_ADD, 8'hF0, 8'h20, 8'h10, 1, 0, "add");

    // Backpressure: tie, port 1 wins since port 0 was granted last
    @(negedge Clk);
    req0_valid = 1; req0_op = OP_ADD; req0_a = 8'd3; req0_b = 8'd4;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 8'd1; req1_b = 8'd2;
    #1;
    check("bp req1_ready", req1_ready, 1);
    check("bp req0_ready", req0_ready, 0);
    @(posedge Clk); #1;
    req1_valid = 0;
    @(posedge Clk); #1;
    check("bp rsp1_valid", rsp1_valid, 1);
    check("bp rsp0_valid", rsp0_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check("bp hold valid", rsp1_valid, 1);
      check("bp hold data", rsp1_data, 8'd3);
      check("bp hold flag", rsp1_flag, 0);
      check("bp req0 blocked", req0_ready, 0);
    end
    rsp1_ready = 1;
    @(posedge Clk); #1;
    rsp1_ready = 0;
    check("bp released", rsp1_valid, 0);
    check("bp req0 now ready", req0_ready, 1);
    @(posedge Clk); #1;
    req0_valid = 0;
    @(posedge Clk); #1;
    check("bp port0 valid", rsp0_valid, 1);
    check("bp port0 data", rsp0_data, 8'd7);
    rsp0_ready = 1;
    @(posedge Clk); #1;
    rsp0_ready = 0;

    // Illegal opcode, then a legal one clears err
    do_op(1, OP_ILL, 8'hAB, 8'hCD, 8'h00, 0, 1, "illegal");
    do_op(1, OP_SNE, 8'h33, 8'h33, 8'h00, 0, 0, "legal after ill");

    // Op sweep
    do_op(0, OP_LSR, 8'h80, 8'd7,  8'h01, 0, 0, "lsr");
    do_op(0, OP_XOR, 8'h5A, 8'h5A, 8'h00, 1, 0, "xor");
    do_op(0, OP_MSK, 8'h0F, 8'hF0, 8'h00, 1, 0, "msk");
    do_op(0, OP_SNE, 8'd3,  8'd4,  8'h01, 1, 0, "sne");

    // Reset during EXEC
    @(negedge Clk);
    req0_valid = 1; req0_op = OP_ADD; req0_a = 8'h11; req0_b = 8'h22;
    @(posedge Clk); #1;
    req0_valid = 0;
    req1_valid = 1;
    check("midrst busy before", busy, 1);
    Reset_n = 0;
    #1;
    check_reset_outputs("midrst");
    req1_valid = 0;
    @(negedge Clk);
    Reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      check("midrst no rsp", rsp0_valid | rsp1_valid, 0);
      check("midrst idle", busy, 0);
    end

    // Tie and fairness from a fresh reset
    apply_reset();
    req0_valid = 1; req0_op = OP_SEQ; req0_a = 8'd5;   req0_b = 8'd5;
    req1_valid = 1; req1_op = OP_LSL; req1_a = 8'h81; req1_b = 8'd1;
    rsp0_ready = 1; rsp1_ready = 1;
    got_n = 0;
    cyc = 0;
    while (got_n < 4 && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
      if (rsp0_valid) begin
        order[got_n] = 0;
        got_n++;
        check("tie seq data", rsp0_data, 8'h01);
        check("tie seq flag", rsp0_flag, 1);
      end else if (rsp1_valid) begin
        order[got_n] = 1;
        got_n++;
        check("tie lsl data", rsp1_data, 8'h02);
        check("tie lsl flag", rsp1_flag, 0);
      end
    end
    check("tie responses seen", got_n, 4);
    for (int i = 0; i < got_n; i++)
      check($sformatf("tie order %0d", i), order[i], i % 2);
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge Clk);
    rsp0_ready = 0; rsp1_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
